// File: rtl/rng_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rng_pkg
//  Description : Shared definitions for the RNG word collector: default word
//                width and the von Neumann pair-state encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package rng_pkg;

  localparam int WORD_W_DEFAULT = 8;

  // Pair FSM: S_FIRST waits for b0, S_SECOND waits for b1.
  typedef enum logic [0:0] {
    S_FIRST  = 1'b0,
    S_SECOND = 1'b1
  } vn_state_e;

endpackage : rng_pkg
`default_nettype wire

// File: rtl/von_neumann_debias.sv
`default_nettype none
// ============================================================================
//  Module      : von_neumann_debias
//  Description : Optional von Neumann debiaser for a serial bit stream.
//                Enabled: non-overlapping pairs (b0,b1); 10 -> 1, 01 -> 0,
//                equal pairs dropped. Disabled: valid bits pass straight
//                through and the pair FSM is held in S_FIRST.
//  Ports       : i_clk        system clock (rising edge)
//                i_rst_n      asynchronous active-low reset
//                i_bit        input bit
//                i_bit_valid  i_bit is meaningful this cycle
//                i_en         1 = debias, 0 = raw pass-through
//                o_bit        accepted bit
//                o_bit_valid  strobe: o_bit is accepted this cycle
//  Revision    : 1.0  initial release
// ============================================================================
module von_neumann_debias
  import rng_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_bit,
  input  logic i_bit_valid,
  input  logic i_en,
  output logic o_bit,
  output logic o_bit_valid
);

  vn_state_e state_q, state_d;
  logic      b0_q, b0_d;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_FIRST;
      b0_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      b0_q    <= b0_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    b0_d        = b0_q;
    o_bit       = b0_q;
    o_bit_valid = 1'b0;

    if (!i_en) begin
      // Raw mode; any half-collected pair is thrown away.
      state_d     = S_FIRST;
      b0_d        = 1'b0;
      o_bit       = i_bit;
      o_bit_valid = i_bit_valid;
    end else if (i_bit_valid) begin
      case (state_q)
        S_FIRST: begin
          b0_d    = i_bit;
          state_d = S_SECOND;
        end
        S_SECOND: begin
          // Unequal pair yields b0; equal pair is discarded.
          o_bit_valid = (b0_q != i_bit);
          state_d     = S_FIRST;
        end
        default: state_d = S_FIRST;
      endcase
    end
  end

endmodule : von_neumann_debias
`default_nettype wire

// File: rtl/rng_word_collector.sv
`default_nettype none
// ============================================================================
//  Module      : rng_word_collector
//  Description : Collects (optionally debiased) random bits into WORD_W-bit
//                words, first accepted bit in the MSB, and offers them on a
//                valid/ready handshake. Words completing while the output is
//                occupied and not being taken are dropped and flagged.
//  Ports       : i_clk, i_rst_n      clock / async active-low reset
//                i_bit, i_bit_valid  serial random bit stream
//                i_debias_en         von Neumann debias enable
//                i_ready             downstream accepts o_word
//                i_ovr_clr           clears o_overrun
//                o_word, o_valid     output word and its valid flag
//                o_overrun           sticky dropped-word flag
//  Revision    : 1.0  initial release
// ============================================================================
module rng_word_collector
  import rng_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEFAULT
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_bit,
  input  logic              i_bit_valid,
  input  logic              i_debias_en,
  input  logic              i_ready,
  input  logic              i_ovr_clr,
  output logic [WORD_W-1:0] o_word,
  output logic              o_valid,
  output logic              o_overrun
);

  localparam int              CNT_W    = $clog2(WORD_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_W - 1);

  logic              w_acc_bit;
  logic              w_acc_valid;
  logic              w_word_done;
  logic              w_load;
  logic              w_drop;
  logic [WORD_W-1:0] w_full_word;

  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;
  logic [WORD_W-1:0] word_q,  word_d;
  logic              valid_q, valid_d;
  logic              ovr_q,   ovr_d;

  von_neumann_debias u_debias (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_bit       (i_bit),
    .i_bit_valid (i_bit_valid),
    .i_en        (i_debias_en),
    .o_bit       (w_acc_bit),
    .o_bit_valid (w_acc_valid)
  );

  assign w_full_word = {shreg_q[WORD_W-2:0], w_acc_bit};
  assign w_word_done = w_acc_valid && (cnt_q == CNT_LAST);
  // The output slot is free if empty or being emptied on this same edge.
  assign w_load      = w_word_done && (!valid_q || i_ready);
  assign w_drop      = w_word_done && valid_q && !i_ready;

  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;

    if (w_acc_valid) begin
      shreg_d = w_full_word;
      cnt_d   = w_word_done ? '0 : cnt_q + 1'b1;
    end

    if (valid_q && i_ready) begin
      valid_d = 1'b0;
    end
    if (w_load) begin
      word_d  = w_full_word;
      valid_d = 1'b1;
    end

    // Set has priority over clear.
    if (w_drop) begin
      ovr_d = 1'b1;
    end else if (i_ovr_clr) begin
      ovr_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      shreg_q <= '0;
      cnt_q   <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign o_word    = word_q;
  assign o_valid   = valid_q;
  assign o_overrun = ovr_q;

endmodule : rng_word_collector
`default_nettype wire

// File: tb/tb_rng_word_collector.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rng_word_collector
//  Description : Self-checking bench for rng_word_collector (WORD_W = 8).
//                Directed scenarios followed by random traffic, all compared
//                against a queue-based reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_rng_word_collector;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         bit_i;
  logic         bv;
  logic         en;
  logic         rdy;
  logic         clr;
  logic [W-1:0] o_word;
  logic         o_valid;
  logic         o_overrun;

  int n_vec;
  int n_err;

  rng_word_collector #(.WORD_W(W)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_bit       (bit_i),
    .i_bit_valid (bv),
    .i_debias_en (en),
    .i_ready     (rdy),
    .i_ovr_clr   (clr),
    .o_word      (o_word),
    .o_valid     (o_valid),
    .o_overrun   (o_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  bit           m_pend;
  bit           m_first;
  bit           m_bits[$];
  logic [W-1:0] m_word;
  bit           m_valid;
  bit           m_ovr;

  task automatic model_reset();
    m_pend  = 0;
    m_first = 0;
    m_bits.delete();
    m_word  = '0;
    m_valid = 0;
    m_ovr   = 0;
  endtask

  task automatic model_edge();
    bit           acc;
    bit           b;
    bit           done;
    logic [W-1:0] w;
    acc  = 0;
    b    = 0;
    done = 0;
    w    = '0;
    if (!en) begin
      m_pend = 0;
      acc    = bv;
      b      = bit_i;
    end else if (bv) begin
      if (!m_pend) begin
        m_pend  = 1;
        m_first = bit_i;
      end else begin
        m_pend = 0;
        if (m_first != bit_i) begin
          acc = 1;
          b   = m_first;
        end
      end
    end
    if (acc) begin
      m_bits.push_back(b);
      if (m_bits.size() == W) begin
        for (int i = 0; i < W; i++) w = {w[W-2:0], m_bits[i]};
        m_bits.delete();
        done = 1;
      end
    end
    if (done && m_valid && !rdy) begin
      m_ovr = 1;
    end else begin
      if (clr) m_ovr = 0;
      if (done) begin
        m_word  = w;
        m_valid = 1;
      end else if (m_valid && rdy) begin
        m_valid = 0;
      end
    end
  endtask

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    check_eq({tag, ".word"},    32'(o_word),    32'(m_word));
    check_eq({tag, ".valid"},   32'(o_valid),   32'(m_valid));
    check_eq({tag, ".overrun"}, 32'(o_overrun), 32'(m_ovr));
  endtask

  // One clock: apply inputs, advance model on the edge, compare after it.
  task automatic tick(input bit b, input bit v, input bit e, input bit r, input bit c);
    bit_i = b;
    bv    = v;
    en    = e;
    rdy   = r;
    clr   = c;
    @(posedge clk);
    model_edge();
    #1;
    check_all("cyc");
  endtask

  task automatic send_byte(input logic [7:0] val, input bit r);
    logic [7:0] v;
    v = val;
    for (int i = 7; i >= 0; i--) tick(v[i], 1'b1, 1'b0, r, 1'b0);
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  logic [21:0] pairs;
  logic [7:0]  raw;

  initial begin
    n_vec = 0;
    n_err = 0;
    bit_i = 0; bv = 0; en = 0; rdy = 0; clr = 0;
    rst_n = 1'b0;
    model_reset();
    #12;
    check_eq("reset.word",    32'(o_word),    32'h0);
    check_eq("reset.valid",   32'(o_valid),   32'h0);
    check_eq("reset.overrun", 32'(o_overrun), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Raw bits, ready high: B2 shows for exactly one cycle.
    send_byte(8'hB2, 1'b1);
    check_eq("raw.word",  32'(o_word),  32'hB2);
    check_eq("raw.valid", 32'(o_valid), 32'h1);
    tick(0, 0, 0, 1, 0);
    check_eq("raw.pulse", 32'(o_valid), 32'h0);

    // Debiased pairs 10,01,11,00,10,10,01,01,00,10,01 -> B2.
    pairs = 22'b10_01_11_00_10_10_01_01_00_10_01;
    for (int i = 21; i >= 0; i--) begin
      tick(pairs[i], 1'b1, 1'b1, 1'b1, 1'b0);
      if (i > 1) check_eq("vn.early_valid", 32'(o_valid), 32'h0);
    end
    check_eq("vn.word",  32'(o_word),  32'hB2);
    check_eq("vn.valid", 32'(o_valid), 32'h1);
    tick(0, 0, 0, 1, 0);

    // Backpressure and overrun.
    send_byte(8'hFF, 1'b0);
    check_eq("bp.valid", 32'(o_valid), 32'h1);
    send_byte(8'h00, 1'b0);
    check_eq("bp.hold_word", 32'(o_word),    32'hFF);
    check_eq("bp.overrun",   32'(o_overrun), 32'h1);
    tick(0, 0, 0, 1, 0);
    check_eq("bp.drain", 32'(o_valid), 32'h0);
    tick(0, 0, 0, 0, 1);
    check_eq("bp.clr", 32'(o_overrun), 32'h0);
    send_byte(8'h5A, 1'b0);
    raw = 8'h33;
    for (int i = 7; i >= 0; i--) tick(raw[i], 1'b1, 1'b0, 1'b0, (i == 0));
    check_eq("bp.set_wins", 32'(o_overrun), 32'h1);
    check_eq("bp.word_kept", 32'(o_word),   32'h5A);
    tick(0, 0, 0, 1, 1);
    check_eq("bp.clr2", 32'(o_overrun), 32'h0);

    // Gapped input: 8 ones spread over 20 cycles.
    for (int i = 0; i < 20; i++) begin
      tick(1'b1, (i % 5 == 1) || (i % 5 == 3), 1'b0, 1'b0, 1'b0);
      if (i < 18) check_eq("gap.no_early", 32'(o_valid), 32'h0);
    end
    check_eq("gap.word", 32'(o_word), 32'hFF);
    tick(0, 0, 0, 1, 0);

    // Reset mid-word: 5 ones then async reset, then 8 zeros.
    for (int i = 0; i < 5; i++) tick(1, 1, 0, 1, 0);
    do_reset();
    send_byte(8'h00, 1'b1);
    check_eq("rst.word",  32'(o_word),  32'h00);
    check_eq("rst.valid", 32'(o_valid), 32'h1);
    tick(0, 0, 0, 1, 0);

    // Debias toggle: stored b0 dropped, next 8 raw bits form AA.
    tick(1, 1, 1, 1, 0);
    send_byte(8'hAA, 1'b1);
    check_eq("tog.word", 32'(o_word), 32'hAA);
    tick(0, 0, 0, 1, 0);

    // Random traffic.
    en = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      bit e;
      e = en;
      if ($urandom_range(0, 63) == 0) e = ~en;
      if ($urandom_range(0, 499) == 0) do_reset();
      tick(1'($urandom), ($urandom_range(0, 3) != 0), e,
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_rng_word_collector
`default_nettype wire
